// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and defaults for the shared Booth multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N    = 32;
  localparam int DEF_NREQ = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/booth_seq_core.sv
// rtl/booth_seq_core.sv - radix-2 Booth iteration registers, one step per enabled cycle
module booth_seq_core
  import mult_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   m,
  input  logic [N-1:0]   q,
  output logic           last_step,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N + 1);

  logic [N:0]    a;
  logic [N-1:0]  qr;
  logic          qm1;
  logic [CW-1:0] count;

  logic [N:0]    m_ext;
  logic [N:0]    sum;
  logic [N:0]    a_nxt;
  logic [N-1:0]  q_nxt;

  // A is one bit wider than M so that M = -2^(N-1) subtracts without overflow.
  always_comb begin
    m_ext = {m[N-1], m};
    sum   = a;
    case ({qr[0], qm1})
      2'b01:   sum = a + m_ext;
      2'b10:   sum = a - m_ext;
      default: sum = a;
    endcase
    a_nxt = {sum[N], sum[N:1]};
    q_nxt = {sum[0], qr[N-1:1]};
  end

  // p is the product as it will stand after the step in progress.
  assign p         = {a_nxt[N-1:0], q_nxt};
  assign last_step = (count == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      qr    <= '0;
      qm1   <= 1'b0;
      count <= '0;
    end else if (load) begin
      a     <= '0;
      qr    <= q;
      qm1   <= 1'b0;
      count <= CW'(N);
    end else if (step) begin
      a     <= a_nxt;
      qr    <= q_nxt;
      qm1   <= qr[0];
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin front end sharing one sequential Booth multiplier
module mult_share_ctrl
  import mult_pkg::*;
#(
  parameter  int N    = DEF_N,
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_m,
  input  logic [NREQ*N-1:0] req_q,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_p,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  cur_id;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [IDW:0]    idx;
  logic [N-1:0]    m_reg;
  logic [N-1:0]    sel_m;
  logic [N-1:0]    sel_q;
  logic            load;
  logic            step;
  logic            last_step;
  logic [2*N-1:0]  p_step;

  // First valid requester at or above ptr, wrapping; idx stays below 2*NREQ.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (IDW + 1)'(i);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!gnt_any && req_valid[idx[IDW-1:0]]) begin
        gnt_any                = 1'b1;
        gnt_id                 = idx[IDW-1:0];
        gnt[idx[IDW-1:0]]      = 1'b1;
      end
    end
  end

  always_comb begin
    sel_m = '0;
    sel_q = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_m = req_m[i*N +: N];
        sel_q = req_q[i*N +: N];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      m_reg  <= '0;
      cur_id <= '0;
      rsp_id <= '0;
      rsp_p  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        m_reg  <= sel_m;
        cur_id <= gnt_id;
        ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end
      if (step && last_step) begin
        rsp_p  <= p_step;
        rsp_id <= cur_id;
      end
    end
  end

  booth_seq_core #(
    .N (N)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .m         (m_reg),
    .q         (sel_q),
    .last_step (last_step),
    .p         (p_step)
  );

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Shares one sequential radix-2 Booth multiplier among `NREQ` requesters. Round-robin arbitration picks a requester and latches its signed operands. The block sequences the N-step Booth iteration and returns the 2N-bit product, tagged with the requester index, through a valid/ready response port. It sits between the requesting units and the multiplier datapath and replaces per-unit multipliers.

## Interface
- `N`, 32: operand width, signed two's complement, N ≥ 2.
- `NREQ`, 4: number of requesters, NREQ ≥ 2. `IDW = $clog2(NREQ)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  bit i: requester i has an operation pending.
- `req_m`  in  NREQ*N  multiplicand of requester i in bits [i*N +: N].
- `req_q`  in  NREQ*N  multiplier of requester i in bits [i*N +: N].
- `req_ready`  out  NREQ  one-hot or zero; bit i means requester i is accepted this cycle.
- `rsp_valid`  out  1  product available.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_p`.
- `rsp_p`  out  2N  signed product M*Q.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - `req_ready` = one-hot grant of the first requester with `req_valid` set, searching upward from pointer `ptr` with wrap-around. This output is combinational from `req_valid`.
  - If any request is valid at the edge: latch M, Q and id; set pointer `ptr` = id+1 mod NREQ; initialise the core with A=0, Q, q₋₁=0, count=N; go to RUN.
- **RUN**
  - Each cycle performs one Booth step on {Q[0], q₋₁}:
    - 01: A += M.
    - 10: A −= M.
    - 00 or 11: no change.
  - After the add/subtract, arithmetic shift right of {A,Q,q₋₁}; count decrements.
  - When the step with count=1 completes, register `rsp_p` = {A,Q}[2N-1:0] and go to DONE.
- **DONE**: `rsp_valid`=1; `rsp_p` and `rsp_id` are stable. Return to IDLE on the edge where `rsp_ready`=1.
- **Width rules**
  - The accumulator A is N+1 bits and M is sign-extended to N+1 bits, so M = −2^(N−1) is exact.
  - (−2^(N−1))² = 2^(2N−2) must be correct.
- **Boundary conditions**
  - `req_ready` is 0 in RUN and DONE. A requester may drop `req_valid` before it is granted; nothing is latched for it.
  - Operand inputs are sampled only on the accept edge; later changes to them have no effect.
  - With `rsp_ready` held low, DONE holds indefinitely and no new grant is issued.
  - All requesters valid: service order follows the pointer, for example 0,1,2,3,0…
  - A requester that stays valid after being accepted is treated as a new request. It competes again on the next IDLE cycle.
  - `rst` during RUN or DONE aborts the operation. No response is produced and the pending request is lost.

## Timing
- **Reset values**: state IDLE, `ptr`=0, `rsp_valid`=0, `rsp_p`=0, `rsp_id`=0, `busy`=0. `req_ready`=0 while `rst` is high.
- **Latency**: accept edge E0 → `rsp_valid` high after edge E0+N.
- **Throughput**: with `rsp_ready` held high, the handshake is at E0+N+1 and IDLE lasts one cycle. The next accept is at E0+N+2, so the minimum period is N+2 cycles.
- **Response order**: in order, one operation in flight.

## Structure
- **Package `mult_pkg`**: state enum (IDLE/RUN/DONE), default N and NREQ, IDW helper function.
- **Sub-module `booth_seq_core`**
  - Holds the A, Q, q₋₁ and count registers.
  - Inputs: `load`, `m`, `q`. Outputs: `last_step`, `p`.
- **`mult_share_ctrl`**: arbiter, FSM, operand and id capture, response register.

## Test plan
- **Single requester**: N=32, req 0 with M=7, Q=2 → one `req_ready`[0] pulse; `rsp_valid` after 32 edges; `rsp_p`=14, `rsp_id`=0.
- **Sign cases on req 2**: (−7,3)→−21, (20,−10)→−200, (−2,−2)→4, (0,−60)→0, (−80,0)→0. Also (−2^31)×(−2^31) → 2^62 and (−2^31)×1 → −2^31.
- **All four requesters valid simultaneously with distinct operands**:
  - Grants occur in order 0,1,2,3.
  - Each `rsp_id`/`rsp_p` pair is correct.
  - Accepts are N+2 cycles apart.
- **Fairness**: after servicing 3, with reqs 0 and 3 both valid → 0 is granted first, then 3.
- **Backpressure**: `rsp_ready` low for 10 cycles in DONE → `rsp_p` and `rsp_id` are stable, `req_ready` stays 0, no second accept until after the handshake.
- **Reset mid-RUN**: assert `rst` at cycle 10 of RUN → outputs return to reset values immediately and no response appears. After release, a new request completes correctly.
